// File: rtl/supply_ramp_gen.sv
// Supply ramp generator: ramps a supply code up to a plateau, holds it,
// then ramps it back to zero, with abort and a real-valued supply output.
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        synchronous active-low reset
//   start        request a ramp sequence (sampled only in IDLE)
//   abort        force an early ramp-down (RAMP_UP / HOLD only)
//   target_code  plateau code, latched on start
//   step_size    code increment per step, latched on start (0 means 1)
//   hold_cycles  plateau duration in cycles, latched on start (0 means 1)
//   busy         high in every state except IDLE
//   done         one-cycle pulse at the end of a sequence
//   code         current supply code
//   vout         VFULL * code / (2^CODE_W - 1), combinational from code
module supply_ramp_gen #(
    parameter int  CODE_W   = 10,
    parameter real VFULL    = 1.8,
    parameter int  STEP_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CODE_W-1:0] target_code,
    input  logic [CODE_W-1:0] step_size,
    input  logic [15:0]       hold_cycles,
    output logic              busy,
    output logic              done,
    output logic [CODE_W-1:0] code,
    output real               vout
);

    localparam int DIV_W =
        (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST =
        DIV_W'(STEP_DIV - 1);

    localparam real FULL_CODE =
        real'((2 ** CODE_W) - 1);

    typedef enum logic [2:0] {
        IDLE,
        RAMP_UP,
        HOLD,
        RAMP_DOWN,
        DONE
    } state_t;

    state_t            state;
    logic [CODE_W-1:0] code_q;
    logic [CODE_W-1:0] tgt_q;
    logic [CODE_W-1:0] step_q;
    logic [15:0]       hold_q;
    logic [15:0]       hold_cnt;
    logic [DIV_W-1:0]  div_q;
    logic              busy_q;
    logic              done_q;

    // Step math is done one bit wider so a ramp near full scale
    // saturates at the target instead of wrapping.
    logic [CODE_W:0]   up_sum;
    logic              up_hit;
    logic [CODE_W-1:0] up_next;
    logic              dn_hit;
    logic [CODE_W-1:0] dn_next;
    logic              div_wrap;
    logic              hold_end;
    logic [CODE_W-1:0] step_in;

    always_comb begin
        up_sum  = {1'b0, code_q} + {1'b0, step_q};
        up_hit  = (up_sum >= {1'b0, tgt_q});
        up_next = up_hit ? tgt_q : up_sum[CODE_W-1:0];
    end

    always_comb begin
        dn_hit  = (code_q <= step_q);
        dn_next = dn_hit ? '0 : (code_q - step_q);
    end

    always_comb begin
        div_wrap = (div_q == DIV_LAST);
    end

    // hold_cnt counts plateau cycles already spent; a zero hold
    // still spends a single cycle in HOLD.
    always_comb begin
        hold_end = (hold_q == 16'd0) ||
                   (hold_cnt == (hold_q - 16'd1));
    end

    always_comb begin
        step_in = (step_size == '0) ?
                  CODE_W'(1) : step_size;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            code_q   <= '0;
            tgt_q    <= '0;
            step_q   <= '0;
            hold_q   <= '0;
            hold_cnt <= '0;
            div_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        tgt_q    <= target_code;
                        step_q   <= step_in;
                        hold_q   <= hold_cycles;
                        div_q    <= '0;
                        hold_cnt <= '0;
                        busy_q   <= 1'b1;
                        if (target_code == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= RAMP_UP;
                        end
                    end
                end

                RAMP_UP: begin
                    if (abort) begin
                        state <= RAMP_DOWN;
                        div_q <= '0;
                    end else if (div_wrap) begin
                        div_q  <= '0;
                        code_q <= up_next;
                        if (up_hit) begin
                            state    <= HOLD;
                            hold_cnt <= '0;
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end

                HOLD: begin
                    if (abort || hold_end) begin
                        state <= RAMP_DOWN;
                        div_q <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
                end

                RAMP_DOWN: begin
                    if (div_wrap) begin
                        div_q  <= '0;
                        code_q <= dn_next;
                        if (dn_hit) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end

                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    div_q  <= '0;
                end

                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    code_q <= '0;
                    div_q  <= '0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign code = code_q;

    // Supply voltage follows the code with no added latency.
    assign vout = VFULL * real'(code_q) / FULL_CODE;

endmodule

// File: tb/tb_supply_ramp_gen.sv
// Scoreboard bench for supply_ramp_gen: stimulus pushes expected
// code/done events, a monitor pops and compares them as they occur.
module tb_supply_ramp_gen;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [9:0]  target_code;
    logic [9:0]  step_size;
    logic [15:0] hold_cycles;
    logic        busy;
    logic        done;
    logic [9:0]  code;
    real         vout;

    supply_ramp_gen #(
        .CODE_W  (10),
        .VFULL   (1.8),
        .STEP_DIV(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .target_code(target_code),
        .step_size  (step_size),
        .hold_cycles(hold_cycles),
        .busy       (busy),
        .done       (done),
        .code       (code),
        .vout       (vout)
    );

    typedef struct {
        bit is_done;
        int val;
        int cyc;
    } ev_t;

    ev_t  q[$];
    int   cyc;
    int   n_tests;
    int   n_fail;
    bit   mon_en;
    int   prev;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    function automatic real rabs(input real x);
        return (x < 0.0) ? -x : x;
    endfunction

    task automatic push(input bit d, input int v, input int c);
        ev_t e;
        e.is_done = d;
        e.val     = v;
        e.cyc     = c;
        q.push_back(e);
    endtask

    task automatic check_ev(input bit d);
        ev_t e;
        n_tests = n_tests + 1;
        if (q.size() == 0) begin
            n_fail = n_fail + 1;
            $display("FAIL unexpected_%s: code=%0d cyc=%0d, none required",
                     d ? "done" : "code", code, cyc);
        end else begin
            e = q.pop_front();
            if (e.is_done != d ||
                (!d && e.val != int'(code)) ||
                e.cyc != cyc) begin
                n_fail = n_fail + 1;
                $display("FAIL event: got done=%0d code=%0d cyc=%0d, required done=%0d code=%0d cyc=%0d",
                         d, code, cyc, e.is_done, e.val, e.cyc);
            end
        end
    endtask

    // Monitor: every code change and every done pulse is an event.
    initial begin
        prev = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (int'(code) != prev) begin
                    check_ev(1'b0);
                    n_tests = n_tests + 1;
                    if (rabs(vout - 1.8 * real'(code) / 1023.0) > 1e-9) begin
                        n_fail = n_fail + 1;
                        $display("FAIL vout_track: got %f for code %0d",
                                 vout, code);
                    end
                    prev = int'(code);
                end
                if (done === 1'b1)
                    check_ev(1'b1);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests = n_tests + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic chk_r(input string nm, input real act, input real exp);
        n_tests = n_tests + 1;
        if (rabs(act - exp) > 1e-9) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %f, required %f", nm, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(posedge clk);
        #1;
    endtask

    task automatic start_seq(input int t, input int s, input int h,
                             input bit ab, output int a);
        @(negedge clk);
        target_code = 10'(t);
        step_size   = 10'(s);
        hold_cycles = 16'(h);
        start       = 1'b1;
        abort       = ab;
        @(posedge clk);
        #1;
        a     = cyc;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while ((q.size() != 0 || busy !== 1'b0) && k < 300) begin
            @(negedge clk);
            k = k + 1;
        end
        chk({nm, "_pending"}, q.size(), 0);
        chk({nm, "_busy_after"}, int'(busy), 0);
        q.delete();
    endtask

    int a;

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        mon_en      = 1'b0;
        rst_n       = 1'b0;
        start       = 1'b1;
        abort       = 1'b0;
        target_code = 10'd5;
        step_size   = 10'd1;
        hold_cycles = 16'd0;

        // Reset state, with start held high and ignored.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_code", int'(code), 0);
        chk_r("rst_vout", vout, 0.0);
        start = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Basic ramp.
        start_seq(100, 25, 3, 1'b0, a);
        chk("basic_busy", int'(busy), 1);
        push(0, 25, a + 4);
        push(0, 50, a + 8);
        push(0, 75, a + 12);
        push(0, 100, a + 16);
        push(0, 75, a + 23);
        push(0, 50, a + 27);
        push(0, 25, a + 31);
        push(0, 0, a + 35);
        push(1, 0, a + 35);
        drain("basic");

        // Saturation near full scale, hold of zero.
        start_seq(1023, 300, 0, 1'b0, a);
        push(0, 300, a + 4);
        push(0, 600, a + 8);
        push(0, 900, a + 12);
        push(0, 1023, a + 16);
        push(0, 723, a + 21);
        push(0, 423, a + 25);
        push(0, 123, a + 29);
        push(0, 0, a + 33);
        push(1, 0, a + 33);
        wait_cyc(a + 16);
        chk_r("sat_vout_plateau", vout, 1.8);
        drain("sat");

        // Abort during HOLD.
        start_seq(100, 40, 10, 1'b0, a);
        push(0, 40, a + 4);
        push(0, 80, a + 8);
        push(0, 100, a + 12);
        push(0, 60, a + 18);
        push(0, 20, a + 22);
        push(0, 0, a + 26);
        push(1, 0, a + 26);
        wait_cyc(a + 13);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        drain("abort");

        // Target zero goes straight to DONE.
        start_seq(0, 5, 4, 1'b0, a);
        push(1, 0, a);
        drain("tgt0");

        // Step zero treated as one; start in RAMP_UP ignored.
        start_seq(3, 0, 0, 1'b0, a);
        push(0, 1, a + 4);
        push(0, 2, a + 8);
        push(0, 3, a + 12);
        push(0, 2, a + 17);
        push(0, 1, a + 21);
        push(0, 0, a + 25);
        push(1, 0, a + 25);
        wait_cyc(a + 1);
        target_code = 10'd7;
        step_size   = 10'd2;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain("step0");

        // Reset while ramping up at code 50.
        start_seq(100, 25, 3, 1'b0, a);
        push(0, 25, a + 4);
        push(0, 50, a + 8);
        push(0, 0, a + 9);
        wait_cyc(a + 8);
        rst_n = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_code", int'(code), 0);
        chk("midrst_busy", int'(busy), 0);
        chk_r("midrst_vout", vout, 0.0);
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_hold_busy", int'(busy), 0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_idle_busy", int'(busy), 0);
        drain("midrst");

        // Start and abort together in IDLE: start wins.
        start_seq(50, 50, 1, 1'b1, a);
        push(0, 50, a + 4);
        push(0, 0, a + 9);
        push(1, 0, a + 9);
        drain("startabort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
